// File: rtl/nco_sweep_pkg.sv
// Shared types and default widths for the NCO frequency-sweep controller.
package nco_sweep_pkg;

    localparam int APR_DEF    = 30;
    localparam int NPW_DEF    = 16;
    localparam int DWW_DEF    = 24;
    localparam int SETTLE_DEF = 16;

    // Sweep direction encodings (direction input exists only in the bidirectional build).
    localparam logic STEP_UP = 1'b0;
    localparam logic STEP_DN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DWELL  = 3'd2,
        ST_STEP   = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and its host/detector.
// NCO_SWEEP_BIDIR_EN adds the sweep-direction input dir_i.
interface nco_sweep_ctrl_if
    import nco_sweep_pkg::*;
#(
    parameter int APR = APR_DEF,
    parameter int NPW = NPW_DEF,
    parameter int DWW = DWW_DEF
) ();

    logic           start_i;
    logic           abort_i;
    logic [APR-1:0] f_start_i;
    logic [APR-1:0] f_step_i;
    logic [NPW-1:0] n_pts_i;
    logic [DWW-1:0] dwell_i;
`ifdef NCO_SWEEP_BIDIR_EN
    logic           dir_i;
`endif
    logic [APR-1:0] phi_inc_o;
    logic           meas_en_o;
    logic           pt_strobe_o;
    logic [NPW-1:0] pt_idx_o;
    logic           busy_o;
    logic           done_o;

    modport master (
        output start_i, abort_i, f_start_i, f_step_i, n_pts_i, dwell_i,
`ifdef NCO_SWEEP_BIDIR_EN
        output dir_i,
`endif
        input  phi_inc_o, meas_en_o, pt_strobe_o, pt_idx_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, f_start_i, f_step_i, n_pts_i, dwell_i,
`ifdef NCO_SWEEP_BIDIR_EN
        input  dir_i,
`endif
        output phi_inc_o, meas_en_o, pt_strobe_o, pt_idx_o, busy_o, done_o
    );

endinterface

// File: rtl/nco_sweep_cnt.sv
// Loadable down-counter gated by clken; saturates at zero, tc_o flags zero.
module nco_sweep_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clken,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over counting; count stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clken) begin
            if (load_i)
                cnt_q <= load_val_i;
            else if (cnt_q != '0)
                cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller: steps the phase increment through n_pts
// points, waits SETTLE cycles per point, then opens a dwell-cycle window.
// Optional build macro NCO_SWEEP_BIDIR_EN enables downward sweeps via dir_i.
//
// state  | meaning
// IDLE   | waiting for start_i
// SETTLE | NCO pipeline settling after an increment change (SETTLE+1 cycles)
// DWELL  | measurement window open, max(dwell,1) cycles
// STEP   | advance phase increment and point index
// DONE   | one-cycle completion pulse
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR    = APR_DEF,
    parameter int NPW    = NPW_DEF,
    parameter int DWW    = DWW_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clken,
    nco_sweep_ctrl_if.slave  bus
);

    localparam int SW = $clog2(SETTLE + 1);

    sweep_state_e   state_q;
    logic [APR-1:0] phi_q;
    logic [APR-1:0] f_step_q;
    logic [NPW-1:0] n_pts_q;
    logic [NPW-1:0] idx_q;
    logic [DWW-1:0] dwell_q;
    logic           meas_q;
    logic           strobe_q;
    logic           busy_q;
    logic           done_q;
`ifdef NCO_SWEEP_BIDIR_EN
    logic           dir_q;
`endif

    logic           settle_load_d;
    logic           dwell_load_d;
    logic [DWW-1:0] dwell_first_d;
    logic [APR-1:0] phi_next_d;
    logic           last_pt_d;
    logic           settle_tc;
    logic           dwell_tc;
    logic [SW-1:0]  settle_cnt_unused;
    logic [DWW-1:0] dwell_cnt;

    // Counter loads and next-point arithmetic derived from current state.
    always_comb begin
        settle_load_d = ((state_q == ST_IDLE) && bus.start_i && (bus.n_pts_i != '0))
                        || (state_q == ST_STEP);
        dwell_load_d  = (state_q == ST_SETTLE) && settle_tc;
        dwell_first_d = (dwell_q == '0) ? '0 : dwell_q - DWW'(1);
        last_pt_d     = (idx_q == n_pts_q - NPW'(1));
`ifdef NCO_SWEEP_BIDIR_EN
        phi_next_d    = (dir_q == STEP_DN) ? phi_q - f_step_q : phi_q + f_step_q;
`else
        phi_next_d    = phi_q + f_step_q;
`endif
    end

    nco_sweep_cnt #(.W(SW)) u_settle_cnt (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .load_i     (settle_load_d),
        .load_val_i (SW'(SETTLE)),
        .cnt_o      (settle_cnt_unused),
        .tc_o       (settle_tc)
    );

    nco_sweep_cnt #(.W(DWW)) u_dwell_cnt (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .load_i     (dwell_load_d),
        .load_val_i (dwell_first_d),
        .cnt_o      (dwell_cnt),
        .tc_o       (dwell_tc)
    );

    // Sweep FSM with registered outputs; abort beats any same-cycle transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phi_q    <= '0;
            f_step_q <= '0;
            n_pts_q  <= '0;
            idx_q    <= '0;
            dwell_q  <= '0;
            meas_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_q    <= STEP_UP;
`endif
        end else if (clken) begin
            if ((state_q != ST_IDLE) && bus.abort_i) begin
                state_q  <= ST_IDLE;
                meas_q   <= 1'b0;
                strobe_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        meas_q   <= 1'b0;
                        strobe_q <= 1'b0;
                        done_q   <= 1'b0;
                        if (bus.start_i) begin
                            f_step_q <= bus.f_step_i;
                            n_pts_q  <= bus.n_pts_i;
                            dwell_q  <= bus.dwell_i;
`ifdef NCO_SWEEP_BIDIR_EN
                            dir_q    <= bus.dir_i;
`endif
                            phi_q    <= bus.f_start_i;
                            idx_q    <= '0;
                            if (bus.n_pts_i == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_SETTLE;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_tc) begin
                            state_q  <= ST_DWELL;
                            meas_q   <= 1'b1;
                            strobe_q <= (dwell_q <= DWW'(1));
                        end
                    end
                    ST_DWELL: begin
                        if (dwell_tc) begin
                            meas_q   <= 1'b0;
                            strobe_q <= 1'b0;
                            if (last_pt_d) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_STEP;
                            end
                        end else begin
                            strobe_q <= (dwell_cnt == DWW'(1));
                        end
                    end
                    ST_STEP: begin
                        phi_q   <= phi_next_d;
                        idx_q   <= idx_q + NPW'(1);
                        state_q <= ST_SETTLE;
                    end
                    ST_DONE: begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.phi_inc_o   = phi_q;
    assign bus.meas_en_o   = meas_q;
    assign bus.pt_strobe_o = strobe_q;
    assign bus.pt_idx_o    = idx_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl (SETTLE = 16).
module tb_nco_sweep_ctrl;
    import nco_sweep_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    nco_sweep_ctrl_if bus_if ();

    nco_sweep_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int k, meas_cnt, strobe_cnt, done_cnt, first_meas, done_k, seen;
    logic [63:0] s_phi [16];
    logic [63:0] s_idx [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [29:0] fs, input logic [29:0] fst,
                            input logic [15:0] np, input logic [23:0] dw);
        bus_if.f_start_i = fs;
        bus_if.f_step_i  = fst;
        bus_if.n_pts_i   = np;
        bus_if.dwell_i   = dw;
    endtask

    task automatic sample();
        if (bus_if.meas_en_o === 1'b1) begin
            meas_cnt++;
            if (first_meas < 0) first_meas = k;
        end
        if (bus_if.pt_strobe_o === 1'b1) begin
            if (strobe_cnt < 16) begin
                s_phi[strobe_cnt] = 64'(bus_if.phi_inc_o);
                s_idx[strobe_cnt] = 64'(bus_if.pt_idx_o);
            end
            strobe_cnt++;
        end
        if (bus_if.done_o === 1'b1) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
        end
    endtask

    // Start a sweep (k=0 is the sample right after the start edge) and record events.
    task automatic run_sweep(input bit toggle, input int budget);
        meas_cnt = 0; strobe_cnt = 0; done_cnt = 0; first_meas = -1; done_k = -1;
        for (int i = 0; i < 16; i++) begin s_phi[i] = '1; s_idx[i] = '1; end
        clken = 1'b1;
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        k = 0;
        for (int it = 0; it < budget; it++) begin
            sample();
            if (done_k >= 0 && k >= done_k + 2) break;
            clken = toggle ? (((k + 1) % 2) == 0) : 1'b1;
            tick();
            k++;
        end
        clken = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b1;
        bus_if.start_i = 1'b0;
        bus_if.abort_i = 1'b0;
        load_cfg(30'd0, 30'd0, 16'd0, 24'd0);
`ifdef NCO_SWEEP_BIDIR_EN
        bus_if.dir_i = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_phi",    64'(bus_if.phi_inc_o),  64'd0);
        chk("rst_idx",    64'(bus_if.pt_idx_o),   64'd0);
        chk("rst_meas",   64'(bus_if.meas_en_o),  64'd0);
        chk("rst_strobe", 64'(bus_if.pt_strobe_o), 64'd0);
        chk("rst_busy",   64'(bus_if.busy_o),     64'd0);
        chk("rst_done",   64'(bus_if.done_o),     64'd0);

        // 1: basic three-point sweep
        load_cfg(30'd1000, 30'd100, 16'd3, 24'd4);
        run_sweep(1'b0, 400);
        chk("t1_first_meas", 64'(first_meas), 64'd17);
        chk("t1_meas_cnt",   64'(meas_cnt),   64'd12);
        chk("t1_strobe_cnt", 64'(strobe_cnt), 64'd3);
        chk("t1_idx0", s_idx[0], 64'd0);
        chk("t1_idx1", s_idx[1], 64'd1);
        chk("t1_idx2", s_idx[2], 64'd2);
        chk("t1_phi0", s_phi[0], 64'd1000);
        chk("t1_phi1", s_phi[1], 64'd1100);
        chk("t1_phi2", s_phi[2], 64'd1200);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_done_k",   64'(done_k),   64'd65);
        chk("t1_busy_end", 64'(bus_if.busy_o),    64'd0);
        chk("t1_phi_hold", 64'(bus_if.phi_inc_o), 64'd1200);

        // 2: zero points
        load_cfg(30'd1234, 30'd100, 16'd0, 24'd4);
        run_sweep(1'b0, 50);
        chk("t2_done_k",   64'(done_k),     64'd0);
        chk("t2_done_cnt", 64'(done_cnt),   64'd1);
        chk("t2_meas",     64'(meas_cnt),   64'd0);
        chk("t2_strobe",   64'(strobe_cnt), 64'd0);

        // 3: wrap of the phase increment, dwell 0 treated as 1
        load_cfg(30'd1073741774, 30'd100, 16'd2, 24'd0);
        run_sweep(1'b0, 200);
        chk("t3_phi0",     s_phi[0], 64'd1073741774);
        chk("t3_phi1",     s_phi[1], 64'd50);
        chk("t3_meas",     64'(meas_cnt),   64'd2);
        chk("t3_strobe",   64'(strobe_cnt), 64'd2);
        chk("t3_first",    64'(first_meas), 64'd17);
        chk("t3_done_k",   64'(done_k),     64'd37);

        // 4: abort in DWELL of point 1; mid-sweep start/input changes ignored
        load_cfg(30'd1000, 30'd100, 16'd3, 24'd4);
        clken = 1'b1;
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        load_cfg(30'd5000, 30'd999, 16'd3, 24'd4);
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("t4_pre_meas", 64'(bus_if.meas_en_o), 64'd1);
        chk("t4_pre_idx",  64'(bus_if.pt_idx_o),  64'd1);
        chk("t4_pre_phi",  64'(bus_if.phi_inc_o), 64'd1100);
        bus_if.abort_i = 1'b1;
        tick();
        bus_if.abort_i = 1'b0;
        chk("t4_ab_meas",   64'(bus_if.meas_en_o),   64'd0);
        chk("t4_ab_busy",   64'(bus_if.busy_o),      64'd0);
        chk("t4_ab_strobe", 64'(bus_if.pt_strobe_o), 64'd0);
        chk("t4_ab_phi",    64'(bus_if.phi_inc_o),   64'd1100);
        chk("t4_ab_idx",    64'(bus_if.pt_idx_o),    64'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.done_o !== 1'b0 || bus_if.meas_en_o !== 1'b0) seen++;
            tick();
        end
        chk("t4_quiet", 64'(seen), 64'd0);
        load_cfg(30'd7, 30'd100, 16'd1, 24'd4);
        run_sweep(1'b0, 200);
        chk("t4_re_phi",  s_phi[0], 64'd7);
        chk("t4_re_idx",  s_idx[0], 64'd0);
        chk("t4_re_done", 64'(done_cnt), 64'd1);
        chk("t4_re_dk",   64'(done_k),   64'd21);

        // 5: clken toggling stretches case 1 by 2x
        load_cfg(30'd1000, 30'd100, 16'd3, 24'd4);
        run_sweep(1'b1, 600);
        chk("t5_first_meas", 64'(first_meas), 64'd34);
        chk("t5_meas_cnt",   64'(meas_cnt),   64'd24);
        chk("t5_strobe_cnt", 64'(strobe_cnt), 64'd6);
        chk("t5_idx4",       s_idx[4],        64'd2);
        chk("t5_phi5",       s_phi[5],        64'd1200);
        chk("t5_done_cnt",   64'(done_cnt),   64'd2);
        chk("t5_done_k",     64'(done_k),     64'd130);

        // 6: asynchronous reset mid-DWELL
        load_cfg(30'd1000, 30'd100, 16'd3, 24'd4);
        clken = 1'b1;
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        chk("t6_pre_meas", 64'(bus_if.meas_en_o), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_phi",    64'(bus_if.phi_inc_o),   64'd0);
        chk("t6_idx",    64'(bus_if.pt_idx_o),    64'd0);
        chk("t6_meas",   64'(bus_if.meas_en_o),   64'd0);
        chk("t6_busy",   64'(bus_if.busy_o),      64'd0);
        chk("t6_strobe", 64'(bus_if.pt_strobe_o), 64'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef NCO_SWEEP_BIDIR_EN
        // bidirectional: downward sweep
        bus_if.dir_i = 1'b1;
        load_cfg(30'd500, 30'd200, 16'd2, 24'd4);
        run_sweep(1'b0, 200);
        chk("bd_phi0", s_phi[0], 64'd500);
        chk("bd_phi1", s_phi[1], 64'd300);
        chk("bd_done", 64'(done_cnt), 64'd1);
        bus_if.dir_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
